// File: rtl/sqrt_iterative.sv
// sqrt_iterative: multi-cycle restoring integer square root, STEPS root bits per cycle,
// with valid/ready handshakes on operand and result.
module sqrt_iterative #(
  parameter int N     = 16,
  parameter int STEPS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   num,
  input  logic           num_vld,
  output logic           num_rdy,
  output logic [N/2-1:0] root,
  output logic [N/2:0]   rem,
  output logic           res_vld,
  input  logic           res_rdy
);
  localparam int R    = N / 2;
  localparam int ITER = N / (2 * STEPS);
  localparam int CW   = ITER > 1 ? $clog2(ITER) : 1;
  if (N % 2 != 0 || N < 4 || STEPS < 1 || R % STEPS != 0) begin : g_bad_params
    $error("sqrt_iterative: N must be even and >= 4, STEPS must divide N/2");
  end
  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  x_q, x_d, x;
  logic [R-1:0]  r_q, r_d, q;
  logic [R+1:0]  p_q, p_d, t;
  logic [R+2:0]  tr;
  logic [R-1:0]  root_q, root_d;
  logic [R:0]    rem_q, rem_d;
  logic          num_rdy_q, num_rdy_d, res_vld_q, res_vld_d;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      r_q       <= '0;
      p_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      num_rdy_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      r_q       <= r_d;
      p_q       <= p_d;
      root_q    <= root_d;
      rem_q     <= rem_d;
      num_rdy_q <= num_rdy_d;
      res_vld_q <= res_vld_d;
    end
  end
  // Stored remainder never exceeds twice the partial root, so it stays non-negative
  // and the shifted value fits R+2 bits; only the trial subtraction needs a sign bit.
  always_comb begin
    q  = r_q;
    t  = p_q;
    x  = x_q;
    tr = '0;
    for (int i = 0; i < STEPS; i++) begin
      t  = {t[R-1:0], x[N-1:N-2]};
      x  = x << 2;
      tr = {1'b0, t} - {1'b0, q, 2'b01};
      t  = tr[R+2] ? t : tr[R+1:0];
      q  = {q[R-2:0], ~tr[R+2]};
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    r_d     = r_q;
    p_d     = p_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (num_vld && num_rdy_q) begin
        state_d = COMP;
        x_d     = num;
        r_d     = '0;
        p_d     = '0;
        cnt_d   = '0;
      end
      COMP: begin
        x_d   = x;
        r_d   = q;
        p_d   = t;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
          root_d  = q;
          rem_d   = t[R:0];
        end
      end
      DONE:    state_d = (res_vld_q && res_rdy) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    num_rdy_d = state_d == IDLE;
    res_vld_d = state_d == DONE;
  end
  assign num_rdy = num_rdy_q;
  assign res_vld = res_vld_q;
  assign root    = root_q;
  assign rem     = rem_q;
endmodule

// File: tb/tb_sqrt_iterative.sv
// tb_sqrt_iterative: directed table, handshake corner cases and a randomized
// scoreboard sweep over several STEPS settings for sqrt_iterative.
module tb_sqrt_iterative;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;
  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint isqrt(input longint n);
    longint r;
    r = longint'($floor($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  logic [15:0] n16 = '0;
  logic        v16 = 1'b0, rr16 = 1'b1, rdy16, rv16;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  sqrt_iterative #(.N(16), .STEPS(1)) d16 (
    .clk(clk), .reset_n(reset_n), .num(n16), .num_vld(v16), .num_rdy(rdy16),
    .root(root16), .rem(rem16), .res_vld(rv16), .res_rdy(rr16));

  logic [31:0] n32 = '0;
  logic        v32 = 1'b0, rr32 = 1'b1, rdy32, rv32;
  logic [15:0] root32;
  logic [16:0] rem32;
  sqrt_iterative #(.N(32), .STEPS(2)) d32 (
    .clk(clk), .reset_n(reset_n), .num(n32), .num_vld(v32), .num_rdy(rdy32),
    .root(root32), .rem(rem32), .res_vld(rv32), .res_rdy(rr32));

  logic [15:0] rn = '0;
  logic        rv = 1'b0, rr = 1'b0, rnd_on = 1'b0;
  for (genvar g = 0; g < 4; g++) begin : gs
    localparam int S = 1 << g;
    logic       rdy, vo;
    logic [7:0] ro;
    logic [8:0] mo;
    longint     q[$];
    longint     a_n, a_e;
    sqrt_iterative #(.N(16), .STEPS(S)) u (
      .clk(clk), .reset_n(reset_n), .num(rn), .num_vld(rv), .num_rdy(rdy),
      .root(ro), .rem(mo), .res_vld(vo), .res_rdy(rr));
    always @(negedge clk) begin
      if (rnd_on) begin
        if (vo && rr) begin
          if (q.size() == 0) chk($sformatf("rnd_s%0d_spurious", S), 1, 0);
          else begin
            a_n = q.pop_front();
            a_e = isqrt(a_n);
            chk($sformatf("rnd_s%0d_root n=%0d", S, a_n), ro, a_e);
            chk($sformatf("rnd_s%0d_rem n=%0d", S, a_n), mo, a_n - a_e * a_e);
            chk($sformatf("rnd_s%0d_sum n=%0d", S, a_n), longint'(ro) * ro + mo, a_n);
          end
        end
        if (rv && rdy) q.push_back(longint'(rn));
      end
    end
  end

  typedef struct {
    logic [15:0] n;
    logic [7:0]  r;
    logic [8:0]  m;
  } vec_t;
  vec_t tv[11];

  task automatic wait_rdy16(input string nm);
    int w = 0;
    while (!rdy16 && w < 60) begin @(negedge clk); w++; end
    chk({nm, "_rdy"}, rdy16, 1);
  endtask

  task automatic op16(input logic [15:0] n, input logic [7:0] er, input logic [8:0] em, input string nm);
    int lat;
    wait_rdy16(nm);
    n16 = n;
    v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    lat = 1;
    while (!rv16 && lat < 60) begin @(negedge clk); lat++; end
    chk({nm, "_lat"}, lat, 9);
    chk({nm, "_root"}, root16, er);
    chk({nm, "_rem"}, rem16, em);
    @(negedge clk);
    chk({nm, "_rdy_after"}, rdy16, 1);
    chk({nm, "_vld_after"}, rv16, 0);
  endtask

  initial begin
    int lat;
    int stale;
    tv[0]  = '{16'd144,   8'd12,  9'd0};
    tv[1]  = '{16'd143,   8'd11,  9'd22};
    tv[2]  = '{16'd0,     8'd0,   9'd0};
    tv[3]  = '{16'd65535, 8'd255, 9'd510};
    tv[4]  = '{16'd200,   8'd14,  9'd4};
    tv[5]  = '{16'd9,     8'd3,   9'd0};
    tv[6]  = '{16'd50,    8'd7,   9'd1};
    tv[7]  = '{16'd1,     8'd1,   9'd0};
    tv[8]  = '{16'd2,     8'd1,   9'd1};
    tv[9]  = '{16'd65025, 8'd255, 9'd0};
    tv[10] = '{16'd65024, 8'd254, 9'd508};
    repeat (3) @(negedge clk);
    chk("reset_rdy", rdy16, 0);
    chk("reset_vld", rv16, 0);
    chk("reset_root", root16, 0);
    chk("reset_rem", rem16, 0);
    chk("reset_rdy32", rdy32, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_rdy", rdy16, 1);
    for (int i = 0; i < 11; i++) op16(tv[i].n, tv[i].r, tv[i].m, $sformatf("tbl%0d", i));
    // backpressure with a second operand waiting
    rr16 = 1'b0;
    wait_rdy16("bp");
    n16 = 16'd200;
    v16 = 1'b1;
    @(negedge clk);
    n16 = 16'd9;
    lat = 1;
    while (!rv16 && lat < 60) begin @(negedge clk); lat++; end
    chk("bp_lat", lat, 9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_root", root16, 14);
      chk("bp_rem", rem16, 4);
      chk("bp_rdy", rdy16, 0);
      chk("bp_vld", rv16, 1);
      @(negedge clk);
    end
    rr16 = 1'b1;
    @(negedge clk);
    chk("bp_idle_rdy", rdy16, 1);
    chk("bp_idle_vld", rv16, 0);
    @(negedge clk);
    v16 = 1'b0;
    lat = 1;
    while (!rv16 && lat < 60) begin @(negedge clk); lat++; end
    chk("bp2_lat", lat, 9);
    chk("bp2_root", root16, 3);
    chk("bp2_rem", rem16, 0);
    @(negedge clk);
    // reset in the third COMP cycle
    wait_rdy16("rst");
    n16 = 16'd40000;
    v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_vld", rv16, 0);
    chk("rst_rdy", rdy16, 0);
    @(negedge clk);
    chk("rst_vld2", rv16, 0);
    chk("rst_rdy2", rdy16, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_rdy", rdy16, 1);
    stale = 0;
    repeat (15) begin @(negedge clk); if (rv16) stale = 1; end
    chk("rst_no_stale", stale, 0);
    op16(16'd50, 8'd7, 9'd1, "post_rst");
    // wide build
    for (int i = 0; i < 2; i++) begin
      int w = 0;
      while (!rdy32 && w < 60) begin @(negedge clk); w++; end
      n32 = i == 0 ? 32'hFFFF_FFFF : 32'd1000000;
      v32 = 1'b1;
      @(negedge clk);
      v32 = 1'b0;
      lat = 1;
      while (!rv32 && lat < 60) begin @(negedge clk); lat++; end
      chk($sformatf("w32_%0d_lat", i), lat, 9);
      chk($sformatf("w32_%0d_root", i), root32, i == 0 ? 65535 : 1000);
      chk($sformatf("w32_%0d_rem", i), rem32, i == 0 ? 131070 : 0);
      @(negedge clk);
    end
    // random sweep with stalls on both sides
    rnd_on = 1'b1;
    repeat (30000) begin
      @(posedge clk);
      #1;
      rn = 16'($urandom);
      rv = ($urandom % 4) != 0;
      rr = ($urandom % 4) != 0;
    end
    @(posedge clk);
    #1;
    rv = 1'b0;
    rr = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rnd_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
